// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Data-memory stage of the 16-bit processor. Accepts one LW/SW request at a
// time from execute, runs it against an internal word array with a fixed
// multi-cycle latency, and returns load data to writeback. The pipeline is
// held through 'stall' for as long as an access is outstanding.
//
// Parameters
//   ADDR_W  word-index width; the array holds 2**ADDR_W 16-bit words
//   LAT     cycles from request accept to response pulse (LAT >= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active HIGH despite the name
//   req_valid   execute presents a request
//   mem_read    request is LW
//   mem_write   request is SW
//   aluResult   byte address, word index = aluResult[ADDR_W:1]
//   writeData   store data
//   req_ready   request is accepted this cycle (high only in IDLE)
//   stall       pipeline hold, high while not IDLE
//   resp_valid  one-cycle response pulse
//   readData    load result, held until the next response
//   err         one-cycle pulse in the response cycle of an illegal request
//
// Optional build macro
//   DMEM_ALIGN_CHECK_EN  when defined, LW/SW with aluResult[0]=1 are flagged
//                        as illegal: full latency, err pulse, no array access.
//                        When undefined, aluResult[0] is simply ignored.
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] aluResult,
    input  logic [15:0] writeData,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [15:0] readData,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Counter only needs to hold LAT-2; keep at least one bit.
    localparam int CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LAT >= 2) ? CNT_W'(LAT - 2) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;

    // Latched request
    logic [ADDR_W-1:0]   idx_r;
    logic [15:0]         wdata_r;
    logic                rd_r;
    logic                wr_r;
    logic                mis_r;

    // Registered outputs
    logic                req_ready_r;
    logic                stall_r;
    logic                resp_valid_r;
    logic [15:0]         read_data_r;
    logic                err_r;

    // Request view used when entering RESP: with LAT==1 that entry happens on
    // the accept edge itself, before the latches hold the request.
    logic [ADDR_W-1:0]   eff_idx_s;
    logic                eff_rd_s;
    logic                eff_wr_s;
    logic                eff_mis_s;
    logic                eff_illegal_s;
    logic                in_mis_s;
    logic                wr_commit_s;
    logic                unused_s;

    logic [15:0]         mem_r [0:DEPTH-1];

    // Upper address bits are deliberately dropped so the index wraps.
    assign unused_s = ^aluResult;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis_s = aluResult[0] & (mem_read | mem_write);
`else
    assign in_mis_s = 1'b0;
`endif

    // Select live inputs in IDLE, latched request otherwise.
    always_comb begin
        eff_idx_s = idx_r;
        eff_rd_s  = rd_r;
        eff_wr_s  = wr_r;
        eff_mis_s = mis_r;
        if (state_r == IDLE) begin
            eff_idx_s = aluResult[ADDR_W:1];
            eff_rd_s  = mem_read;
            eff_wr_s  = mem_write;
            eff_mis_s = in_mis_s;
        end else begin
            eff_idx_s = idx_r;
            eff_rd_s  = rd_r;
            eff_wr_s  = wr_r;
            eff_mis_s = mis_r;
        end
        eff_illegal_s = (eff_rd_s & eff_wr_s) | eff_mis_s;
    end

    // Next-state and latency counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (LAT == 1) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_INIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {ADDR_W{1'b0}};
            wdata_r      <= 16'h0000;
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
            mis_r        <= 1'b0;
            req_ready_r  <= 1'b1;
            stall_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            read_data_r  <= 16'h0000;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            req_ready_r  <= (state_s == IDLE);
            stall_r      <= (state_s != IDLE);
            resp_valid_r <= (state_s == RESP);
            err_r        <= (state_s == RESP) & eff_illegal_s;
            if (state_r == IDLE && req_valid) begin
                idx_r   <= aluResult[ADDR_W:1];
                wdata_r <= writeData;
                rd_r    <= mem_read;
                wr_r    <= mem_write;
                mis_r   <= in_mis_s;
            end
            // Load data is captured on entry to RESP so it is valid in RESP.
            if (state_s == RESP) begin
                if (eff_illegal_s) begin
                    read_data_r <= read_data_r;
                end else if (eff_rd_s) begin
                    read_data_r <= mem_r[eff_idx_s];
                end else if (eff_wr_s) begin
                    read_data_r <= read_data_r;
                end else begin
                    read_data_r <= 16'h0000;
                end
            end
        end
    end

    // Store commits on the edge leaving RESP; reset in RESP suppresses it.
    assign wr_commit_s = ~rst_n & (state_r == RESP) & wr_r & ~rd_r & ~mis_r;

    // Word array write port (contents are never reset).
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    assign req_ready  = req_ready_r;
    assign stall      = stall_r;
    assign resp_valid = resp_valid_r;
    assign readData   = read_data_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed self-checking bench for mem_access_stage (ADDR_W=10, LAT=2).
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] aluResult;
    logic [15:0] writeData;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [15:0] readData;
    logic        err;

    int total;
    int bad;

    mem_access_stage #(
        .ADDR_W(10),
        .LAT   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .aluResult (aluResult),
        .writeData (writeData),
        .req_ready (req_ready),
        .stall     (stall),
        .resp_valid(resp_valid),
        .readData  (readData),
        .err       (err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it until the block is idle again.
    task automatic do_req(input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output int stalls,
                          output logic [15:0] rdata, output logic errv);
        bit done;
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        aluResult = addr;
        writeData = data;
        tick();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        lat    = -1;
        stalls = 0;
        rdata  = 16'h0000;
        errv   = 1'b0;
        done   = 1'b0;
        for (int i = 1; i <= 10 && !done; i++) begin
            if (stall) stalls++;
            if (resp_valid) begin
                lat   = i;
                rdata = readData;
                errv  = err;
                done  = 1'b1;
            end
            tick();
        end
    endtask

    int          lat;
    int          stalls;
    logic [15:0] rd;
    logic        ev;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        aluResult = 16'h0000;
        writeData = 16'h0000;

        // Reset state
        tick();
        tick();
        check_val("rst_req_ready",  {15'd0, req_ready},  16'd1);
        check_val("rst_stall",      {15'd0, stall},      16'd0);
        check_val("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
        check_val("rst_readData",   readData,            16'h0000);
        check_val("rst_err",        {15'd0, err},        16'd0);
        rst_n = 1'b0;
        tick();

        // SW/LW round trip
        do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, stalls, rd, ev);
        check_val("sw_lat",    16'(lat),    16'd2);
        check_val("sw_stalls", 16'(stalls), 16'd2);
        check_val("sw_err",    {15'd0, ev}, 16'd0);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, ev);
        check_val("lw_lat",    16'(lat),    16'd2);
        check_val("lw_stalls", 16'(stalls), 16'd2);
        check_val("lw_data",   rd,          16'hBEEF);
        check_val("lw_held",   readData,    16'hBEEF);
        check_val("idle_ready", {15'd0, req_ready}, 16'd1);

        // Index wrap: 0x0804 and 0x0004 hit the same word
        do_req(1'b0, 1'b1, 16'h0804, 16'h1234, lat, stalls, rd, ev);
        check_val("wrap_sw_lat", 16'(lat), 16'd2);
        do_req(1'b1, 1'b0, 16'h0004, 16'h0000, lat, stalls, rd, ev);
        check_val("wrap_lw_data", rd, 16'h1234);

        // Illegal op with readData previously 0xBEEF
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, ev);
        check_val("pre_ill_data", rd, 16'hBEEF);
        do_req(1'b1, 1'b1, 16'h0010, 16'h0000, lat, stalls, rd, ev);
        check_val("ill_lat",  16'(lat),    16'd2);
        check_val("ill_err",  {15'd0, ev}, 16'd1);
        check_val("ill_data", rd,          16'hBEEF);
        check_val("ill_err_clear", {15'd0, err}, 16'd0);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, ev);
        check_val("post_ill_lw", rd, 16'hBEEF);

        // Neither op: response pulses, readData cleared, no write
        do_req(1'b0, 1'b0, 16'h0010, 16'h7777, lat, stalls, rd, ev);
        check_val("nop_lat",  16'(lat),    16'd2);
        check_val("nop_data", rd,          16'h0000);
        check_val("nop_err",  {15'd0, ev}, 16'd0);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, ev);
        check_val("post_nop_lw", rd, 16'hBEEF);

        // Reset in RESP aborts the store
        do_req(1'b0, 1'b1, 16'h0020, 16'h5555, lat, stalls, rd, ev);
        req_valid = 1'b1;
        mem_write = 1'b1;
        aluResult = 16'h0020;
        writeData = 16'hAAAA;
        tick();
        req_valid = 1'b0;
        mem_write = 1'b0;
        check_val("mid_wait_ready", {15'd0, req_ready}, 16'd0);
        tick();
        check_val("mid_resp", {15'd0, resp_valid}, 16'd1);
        rst_n = 1'b1;
        tick();
        check_val("mid_rst_resp",  {15'd0, resp_valid}, 16'd0);
        check_val("mid_rst_stall", {15'd0, stall},      16'd0);
        check_val("mid_rst_data",  readData,            16'h0000);
        rst_n = 1'b0;
        tick();
        check_val("mid_after_resp", {15'd0, resp_valid}, 16'd0);
        tick();
        check_val("mid_after_resp2", {15'd0, resp_valid}, 16'd0);
        do_req(1'b1, 1'b0, 16'h0020, 16'h0000, lat, stalls, rd, ev);
        check_val("mid_lw_data", rd, 16'h5555);

        // Misaligned load of the word at 0x0010
        do_req(1'b1, 1'b0, 16'h0011, 16'h0000, lat, stalls, rd, ev);
        check_val("mis_lat", 16'(lat), 16'd2);
`ifdef DMEM_ALIGN_CHECK_EN
        check_val("mis_err",  {15'd0, ev}, 16'd1);
        check_val("mis_data", rd,          16'h5555);
`else
        check_val("mis_err",  {15'd0, ev}, 16'd0);
        check_val("mis_data", rd,          16'hBEEF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory stage of the 16-bit single-cycle processor. Consumes the execute stage's address (aluResult) and store data (writeData).
- Performs LW/SW against an internal word array with configurable multi-cycle latency. Returns load data to writeback.
- Holds the pipeline via stall while an access is outstanding.
- Receiving end of the execute-to-memory interface.

Parameters:
- ADDR_W, 10: word-index width; array holds 2**ADDR_W 16-bit words.
- LAT, 2: cycles from request accept to response. Legal range is LAT >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1).
- req_valid  in  1  execute presents a request this cycle.
- mem_read  in  1  request is LW.
- mem_write  in  1  request is SW.
- aluResult  in  16  byte address; word index = aluResult[ADDR_W:1].
- writeData  in  16  store data.
- req_ready  out  1  block accepts a request this cycle.
- stall  out  1  pipeline hold; high while not idle.
- resp_valid  out  1  one-cycle response pulse.
- readData  out  16  load result. Held until the next response.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
Reset values:
- FSM goes to IDLE; latency counter = 0.
- req_ready=1, stall=0, resp_valid=0, readData=0, err=0.
- Array contents are not reset.

FSM states:
- IDLE: req_ready=1, stall=0. A request is accepted when req_valid=1; its address, data and op are latched.
  - Go to RESP if LAT==1, otherwise go to WAIT with counter=LAT-2.
- WAIT: req_ready=0, stall=1. Counter decrements each cycle; go to RESP when counter==0 at the edge.
- RESP: req_ready=0, stall=1, resp_valid=1.
  - The access is performed this cycle.
    - LW: readData <= mem[idx] (registered, visible the cycle after RESP alongside the next state). Correction: readData must be valid in the RESP cycle, so mem is read combinationally from the latched index and registered into readData on entry to RESP.
    - SW: mem[idx] <= latched writeData at the RESP edge.
  - Next state is IDLE.

Latency:
- An accept at edge T gives resp_valid high during cycle T+LAT.
- The earliest next accept is at cycle T+LAT+1.

Op rules:
- mem_read=1 and mem_write=1 together: accepted, no array access, err pulses in RESP, readData unchanged.
- Neither op set: accepted, resp_valid pulses after LAT, readData = 0, no write.
- req_valid while not in IDLE: ignored. The source must hold the request because stall is high.
- Index wrap: address bits above ADDR_W are ignored, so the index wraps modulo 2**ADDR_W.

Load after store:
- A LW following a SW to the same word returns the stored value. The write commits before the next accept.

Reset mid-operation:
- Reset in WAIT or RESP aborts the access. In RESP the reset takes priority, so no write is committed and no resp_valid is produced after reset.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a request with aluResult[0]=1 and mem_read or mem_write set is accepted and runs the full LAT cycles. In RESP it makes no array access, pulses err, and leaves readData unchanged.
- Undefined: aluResult[0] is ignored, and misaligned addresses access the enclosing word normally.

Test Plan:
- Reset then idle: hold rst_n=1 for 2 cycles -> req_ready=1, stall=0, resp_valid=0, readData=0x0000, err=0.
- SW/LW round trip (LAT=2): SW addr 0x0010 data 0xBEEF, then LW addr 0x0010 -> each resp_valid exactly 2 cycles after accept; LW readData=0xBEEF; stall high for 2 cycles per access.
- Wrap-around (ADDR_W=10): SW addr 0x0804 data 0x1234, then LW addr 0x0004 -> readData=0x1234.
- Illegal op: req_valid with mem_read=mem_write=1, readData previously 0xBEEF -> err pulses in the response cycle, readData stays 0xBEEF, and a subsequent LW of that word is unchanged.
- Reset mid-op: SW addr 0x0020 data 0xAAAA, then assert rst_n during the RESP cycle; later LW 0x0020 after writing 0x5555 there earlier -> returns 0x5555, and no resp_valid after reset.
- Alignment (DMEM_ALIGN_CHECK_EN defined): LW addr 0x0011 -> err pulse, readData unchanged. Undefined: same LW returns the word at 0x0010.
